adder64_seq_ctrl: RTL and testbench

- Multi-cycle controller that performs a WIDTH-bit addition by time-multiplexing one 16-bit adder slice (sixteen_bit_adder: A, B, c0 -> output1, cout).
- Processes one 16-bit beat per clock, from the LSB beat upward, and registers the inter-beat carry.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.
- Provides the area-reduced alternative to the flat 64-bit adders.

---
 rtl/adder64_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_adder64_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder64_seq_ctrl.sv
// Sequential WIDTH-bit adder: one 16-bit slice reused once per beat, LSB beat first,
// with the inter-beat carry held in a register. Valid/ready on both sides.

module sixteen_bit_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        c0,
  output logic [15:0] output1,
  output logic        cout
);
  assign {cout, output1} = {1'b0, A} + {1'b0, B} + {16'b0, c0};
endmodule

module adder64_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / 16;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BW-1:0]    r_beat;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [BW+3:0]    w_lsb;
  logic [15:0]      w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;

  assign w_lsb  = {r_beat, 4'b0000};
  assign w_last = (r_beat == BW'(N - 1));

  sixteen_bit_adder u_slice (
    .A       (r_a[w_lsb +: 16]),
    .B       (r_b[w_lsb +: 16]),
    .c0      (r_carry),
    .output1 (w_slice_sum),
    .cout    (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
    // Abort wins over every handshake, including a pending delivery in DONE.
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_beat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_beat  <= '0;
          end
        end
        S_CALC: begin
          r_sum[w_lsb +: 16] <= w_slice_sum;
          r_carry            <= w_slice_cout;
          if (w_last) begin
            r_beat <= '0;
            r_cout <= w_slice_cout;
            // Sign bit taken from the live slice output; r_sum's top beat is stale here.
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[15] != r_a[WIDTH-1]);
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Directed bench for adder64_seq_ctrl at WIDTH=64: carry ripple, overflow, backpressure,
// clear, async reset mid-operation and a pair of random operations against a+b+cin.

module tb_adder64_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  adder64_seq_ctrl #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                        input logic vc, input logic [63:0] es, input logic ec,
                        input logic eo, input int hold);
    int lat;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, 64'(cout), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = ~cin;
      tick();
      chk({tag, " hold sum"}, sum, es);
      chk({tag, " hold cout"}, 64'(cout), 64'(ec));
      chk({tag, " hold ovf"}, 64'(ovf), 64'(eo));
      chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] ref_full;
    logic        ref_ovf;
    int          seen_valid;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset sum", sum, 64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 0);
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 0);
    run_op("cin_beats", 64'h0000_FFFF_0000_FFFF, 64'd0, 1'b1, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 0);
    run_op("backpressure", 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 6);

    // Abort at beat 2 of CALC.
    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("clear pre busy", 64'(busy), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear in_ready", 64'(in_ready), 64'd1);
    chk("clear busy", 64'(busy), 64'd0);
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("clear no out_valid", 64'(seen_valid), 64'd0);
    run_op("after_clear", 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0, 0);

    // clear together with in_valid in IDLE must not capture.
    a = 64'h5; b = 64'h6; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    chk("clear idle in_ready", 64'(in_ready), 64'd1);
    chk("clear idle busy", 64'(busy), 64'd0);

    // Async reset mid-CALC, checked before the next rising edge.
    a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst sum", sum, 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 2; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1, 0));
      ref_full = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
      ref_ovf = (ra[63] == rb[63]) && (ref_full[63] != ra[63]);
      run_op("random", ra, rb, rc, ref_full[63:0], ref_full[64], ref_ovf, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
